// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace multiplier.
// Row-count helpers size each reduction level of the carry-save tree.
package wallace_pkg;

    localparam int W_DEF = 8;
    localparam int P_W   = 2 * W_DEF;

    // One 3:2 layer turns every full group of three rows into two; leftovers pass through.
    function automatic int rows_next(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int rows_at(input int n0, input int lv);
        int n;
        n = n0;
        for (int i = 0; i < lv; i++) begin
            n = rows_next(n);
        end
        return n;
    endfunction

    // Number of compressor levels needed to bring n0 rows down to two.
    function automatic int wallace_levels(input int n0);
        int n;
        int lv;
        n  = n0;
        lv = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 2) begin
                n  = rows_next(n);
                lv = lv + 1;
            end
        end
        return lv;
    endfunction

    function automatic logic [63:0] bw_const(input int w);
        return (64'd1 << w) | (64'd1 << (2 * w - 1));
    endfunction

endpackage

// File: rtl/wallace_mult_pipe_csa_row.sv
// Row of 3:2 full-adder cells; the carry vector is already weighted (shifted left by one).
// The carry out of the top bit falls off, which is harmless for modulo-2^N products.
module csa_row #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_c,
    output logic [N-1:0] o_sum,
    output logic [N-1:0] o_carry
);
    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = {(i_a[N-2:0] & i_b[N-2:0]) |
                      (i_a[N-2:0] & i_c[N-2:0]) |
                      (i_b[N-2:0] & i_c[N-2:0]), 1'b0};
endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage W x W multiplier: operand register, Wallace carry-save register, final-sum register.
// Signed mode uses Baugh-Wooley rows plus one constant row, so both modes share one tree.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    input  logic            in_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out_p
);
    localparam int              PW       = 2 * W;
    localparam int              N_ROWS   = W + 1;
    localparam int              N_LV     = wallace_levels(N_ROWS);
    localparam logic [PW-1:0]   BW_C     = PW'(bw_const(W));
    localparam logic [W-1:0]    MSB_ONLY = W'(1) << (W - 1);

    logic            w_en;
    logic            r_v1, r_v2, r_v3;
    logic [W-1:0]    r_a, r_b;
    logic            r_sgn;
    logic [PW-1:0]   r_sum, r_carry, r_p;
    logic [PW-1:0]   w_pp [N_ROWS];
    logic [PW-1:0]   w_fsum, w_fcarry;

    assign w_en      = !r_v3 || out_ready;
    assign in_ready  = w_en && !rst;
    assign out_valid = r_v3;
    assign out_p     = r_p;

    for (genvar i = 0; i < W; i++) begin : g_pp
        localparam logic [W-1:0] INV = (i < W - 1) ? MSB_ONLY : ~MSB_ONLY;
        assign w_pp[i] = PW'((r_a & {W{r_b[i]}}) ^ (r_sgn ? INV : '0)) << i;
    end
    // Extra row carries the Baugh-Wooley correction; zero in unsigned mode.
    assign w_pp[W] = r_sgn ? BW_C : '0;

    for (genvar lv = 0; lv < N_LV; lv++) begin : g_lv
        localparam int N_CUR = rows_at(N_ROWS, lv);
        localparam int N_GRP = N_CUR / 3;
        localparam int N_NXT = rows_at(N_ROWS, lv + 1);

        logic [PW-1:0] w_in  [N_CUR];
        logic [PW-1:0] w_out [N_NXT];

        if (lv == 0) begin : g_first
            assign w_in = w_pp;
        end else begin : g_next
            assign w_in = g_lv[lv-1].w_out;
        end

        for (genvar g = 0; g < N_GRP; g++) begin : g_csa
            csa_row #(.N(PW)) u_csa (
                .i_a     (w_in[3*g]),
                .i_b     (w_in[3*g+1]),
                .i_c     (w_in[3*g+2]),
                .o_sum   (w_out[2*g]),
                .o_carry (w_out[2*g+1])
            );
        end

        for (genvar k = 0; k < N_CUR % 3; k++) begin : g_pass
            assign w_out[2*N_GRP+k] = w_in[3*N_GRP+k];
        end
    end

    assign w_fsum   = g_lv[N_LV-1].w_out[0];
    assign w_fcarry = g_lv[N_LV-1].w_out[1];

    // All stages move together; bubbles are kept rather than collapsed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sgn   <= 1'b0;
            r_sum   <= '0;
            r_carry <= '0;
            r_p     <= '0;
        end else if (w_en) begin
            r_v1    <= in_valid;
            r_a     <= in_a;
            r_b     <= in_b;
            r_sgn   <= in_signed;
            r_v2    <= r_v1;
            r_sum   <= w_fsum;
            r_carry <= w_fcarry;
            r_v3    <= r_v2;
            r_p     <= r_sum + r_carry;
        end
    end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Scoreboard bench for wallace_mult_pipe at W = 4, 8 and 16: directed corners on W = 8,
// then a randomised sweep on all three instances against an arithmetic reference.
module tb_wallace_mult_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] st_a  [3];
    logic [31:0] st_b  [3];
    logic        st_s  [3];
    logic        st_v  [3];
    logic        st_or [3];
    logic        dut_ir [3];
    logic        dut_ov [3];
    logic [63:0] dut_p  [3];
    int          n_out [3];
    int          q_len [3];
    int          errors;
    int          checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int w_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 8 : 16;
    endfunction

    // Reference: interpret operands as plain integers for the mode, multiply, keep 2w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic s);
        logic [31:0]         amask;
        logic [63:0]         pmask;
        logic signed [65:0]  ea, eb;
        logic signed [131:0] pr;
        amask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        pmask = (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        ea = $signed({34'd0, a & amask});
        eb = $signed({34'd0, b & amask});
        if (s && a[w-1]) ea = ea - (66'sd1 <<< w);
        if (s && b[w-1]) eb = eb - (66'sd1 <<< w);
        pr = ea * eb;
        return pr[63:0] & pmask;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int WK = w_of(k);
        logic [2*WK-1:0] w_p;
        logic [63:0]     q[$];

        wallace_mult_pipe #(.W(WK)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (st_v[k]),
            .in_ready  (dut_ir[k]),
            .in_a      (st_a[k][WK-1:0]),
            .in_b      (st_b[k][WK-1:0]),
            .in_signed (st_s[k]),
            .out_valid (dut_ov[k]),
            .out_ready (st_or[k]),
            .out_p     (w_p)
        );
        assign dut_p[k] = 64'(w_p);

        // Inputs are stable here until the next rising edge, so these are the transfers it will make.
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
            end else begin
                if (dut_ov[k] && st_or[k]) begin
                    check($sformatf("w%0d output expected", WK), 64'(q.size() > 0), 64'd1);
                    if (q.size() > 0) check($sformatf("w%0d product", WK), dut_p[k], q.pop_front());
                    n_out[k]++;
                end
                if (st_v[k] && dut_ir[k]) q.push_back(ref_mul(WK, st_a[k], st_b[k], st_s[k]));
            end
            q_len[k] = q.size();
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
        bit got;
        got = 1'b0;
        st_a[1] = {24'd0, a};
        st_b[1] = {24'd0, b};
        st_s[1] = s;
        st_v[1] = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (dut_ir[1]) begin
                got = 1'b1;
                break;
            end
        end
        check("send8 accepted", 64'(got), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov8(output bit seen);
        seen = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (dut_ov[1]) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] corner_exp [5];
        int          base;
        logic [63:0] hold;
        bit          seen;

        errors = 0;
        checks = 0;
        rst    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            st_a[k] = '0; st_b[k] = '0; st_s[k] = 1'b0; st_v[k] = 1'b0; st_or[k] = 1'b1;
            n_out[k] = 0; q_len[k] = 0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset out_valid", 64'(dut_ov[k]), 64'd0);
            check("reset out_p", dut_p[k], 64'd0);
            check("reset in_ready", 64'(dut_ir[k]), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check("in_ready after reset", 64'(dut_ir[k]), 64'd1);
        @(posedge clk); #1;

        // Latency: three edges from the handshake cycle to a valid product.
        send8(8'hFF, 8'hFF, 1'b0);
        st_v[1] = 1'b0;
        @(negedge clk); check("latency cycle1 out_valid", 64'(dut_ov[1]), 64'd0);
        @(negedge clk); check("latency cycle2 out_valid", 64'(dut_ov[1]), 64'd0);
        @(negedge clk); check("latency cycle3 out_valid", 64'(dut_ov[1]), 64'd1);
        check("unsigned max", dut_p[1], 64'hFE01);
        @(posedge clk); #1;

        // Signed corners followed by mixed-mode back-to-back.
        corner_exp[0] = 16'h4000; corner_exp[1] = 16'hFFFF; corner_exp[2] = 16'hC080;
        corner_exp[3] = 16'hFE01; corner_exp[4] = 16'h0001;
        fork
            begin
                send8(8'h80, 8'h80, 1'b1);
                send8(8'hFF, 8'h01, 1'b1);
                send8(8'h80, 8'h7F, 1'b1);
                send8(8'hFF, 8'hFF, 1'b0);
                send8(8'hFF, 8'hFF, 1'b1);
                st_v[1] = 1'b0;
            end
            begin
                wait_ov8(seen);
                check("corner output seen", 64'(seen), 64'd1);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check($sformatf("corner %0d out_valid", i), 64'(dut_ov[1]), 64'd1);
                    check($sformatf("corner %0d product", i), dut_p[1], 64'(corner_exp[i]));
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Empty pipe ignores out_ready; then back-pressure with five pairs.
        st_or[1] = 1'b0;
        @(negedge clk);
        check("empty pipe in_ready", 64'(dut_ir[1]), 64'd1);
        @(posedge clk); #1;
        base = n_out[1];
        fork
            begin
                for (int i = 0; i < 5; i++) send8(8'(i * 37 + 3), 8'(i * 29 + 200), 1'(i % 2));
                st_v[1] = 1'b0;
            end
            begin
                wait_ov8(seen);
                check("stall output seen", 64'(seen), 64'd1);
                hold = dut_p[1];
                check("stall in_ready", 64'(dut_ir[1]), 64'd0);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall out_valid held", 64'(dut_ov[1]), 64'd1);
                    check("stall out_p held", dut_p[1], hold);
                    check("stall in_ready held", 64'(dut_ir[1]), 64'd0);
                end
                @(posedge clk); #1;
                st_or[1] = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        check("backpressure product count", 64'(n_out[1] - base), 64'd5);
        check("backpressure queue drained", 64'(q_len[1]), 64'd0);

        // Reset with three transactions in flight.
        send8(8'h11, 8'h22, 1'b0);
        send8(8'h33, 8'h44, 1'b1);
        send8(8'h55, 8'h66, 1'b0);
        st_v[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midflight reset out_valid", 64'(dut_ov[1]), 64'd0);
        check("midflight reset out_p", dut_p[1], 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send8(8'h12, 8'h34, 1'b0);
        st_v[1] = 1'b0;
        wait_ov8(seen);
        check("post-reset output seen", 64'(seen), 64'd1);
        check("post-reset first product", dut_p[1], 64'h03A8);
        @(posedge clk); #1;

        // Randomised sweep on all widths with random back-pressure.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 3; k++) begin
                st_v[k]  = ($urandom_range(3) != 0);
                st_a[k]  = $urandom;
                st_b[k]  = $urandom;
                if ($urandom_range(7) == 0) st_a[k] = 32'd1 << (w_of(k) - 1);
                if ($urandom_range(7) == 0) st_b[k] = 32'd1 << (w_of(k) - 1);
                st_s[k]  = 1'($urandom_range(1));
                st_or[k] = ($urandom_range(2) != 0);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            st_v[k]  = 1'b0;
            st_or[k] = 1'b1;
        end
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("w%0d final queue empty", w_of(k)), 64'(q_len[k]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
